// File: rtl/split_rr_arbiter.sv
`timescale 1ns/1ps
// split_rr_arbiter
// Round-robin arbiter for N_MASTERS masters sharing one bus, with a grant
// timeout and per-slave split-transaction tracking.
// Optional feature macro: ARB_SPLIT_EN
//   defined   : split table, resume priority, B_SPLIT, B_SPL_RESUME, SPLIT_PEND
//   undefined : pure round-robin with timeout; split outputs tied low and
//               S_SPLIT / S_READY ignored.
// All outputs come straight from flops.

module split_rr_arbiter #(
    parameter int N_MASTERS     = 4,
    parameter int N_SLAVES      = 3,
    parameter int GRANT_TIMEOUT = 16
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic [N_MASTERS-1:0] M_REQ,
    output logic [N_MASTERS-1:0] M_GRANT,
    input  logic                 B_UTIL,
    input  logic [N_SLAVES-1:0]  S_SPLIT,
    input  logic [N_SLAVES-1:0]  S_READY,
    output logic                 B_SPLIT,
    output logic                 B_SPL_RESUME,
    output logic [N_SLAVES-1:0]  SPLIT_PEND
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CNT_W = (GRANT_TIMEOUT > 2) ? $clog2(GRANT_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        UTIL  = 2'd2
    } state_t;

    // Master index to one-hot grant vector.
    function automatic logic [N_MASTERS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [N_MASTERS-1:0] one_v;
        one_v = {{(N_MASTERS-1){1'b0}}, 1'b1};
        return one_v << idx;
    endfunction

    state_t                 state_r,     state_nxt_s;
    logic [N_MASTERS-1:0]   grant_r,     grant_nxt_s;
    logic [IDX_W-1:0]       gnt_idx_r,   gnt_idx_nxt_s;
    logic [IDX_W-1:0]       rr_ptr_r,    rr_ptr_nxt_s;
    logic [CNT_W-1:0]       cnt_r,       cnt_nxt_s;

    logic [N_MASTERS-1:0]   parked_s;
    logic [N_MASTERS-1:0]   elig_s;
    logic                   rr_found_s;
    logic [IDX_W-1:0]       rr_idx_s;
    logic [IDX_W-1:0]       rr_cand_s;

`ifdef ARB_SPLIT_EN
    localparam int SLV_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    logic [N_SLAVES-1:0]    spl_valid_r, spl_valid_nxt_s;
    logic [IDX_W-1:0]       spl_owner_r     [N_SLAVES];
    logic [IDX_W-1:0]       spl_owner_nxt_s [N_SLAVES];
    logic                   b_split_r,   b_split_nxt_s;
    logic                   resume_r,    resume_nxt_s;

    logic                   res_found_s;
    logic                   res_hit_s;
    logic [SLV_W-1:0]       res_slave_s;
    logic [IDX_W-1:0]       res_owner_s;
    logic                   spl_any_s;
    logic [SLV_W-1:0]       spl_slave_s;

    // Masters currently parked behind any valid split entry.
    always_comb begin
        parked_s = {N_MASTERS{1'b0}};
        for (int s = 0; s < N_SLAVES; s++) begin
            parked_s = parked_s |
                       (spl_valid_r[s] ? idx_onehot(spl_owner_r[s]) : {N_MASTERS{1'b0}});
        end
    end

    // Lowest-numbered ready split entry whose owner is still requesting.
    always_comb begin
        res_found_s = 1'b0;
        res_hit_s   = 1'b0;
        res_slave_s = {SLV_W{1'b0}};
        res_owner_s = {IDX_W{1'b0}};
        for (int s = N_SLAVES - 1; s >= 0; s--) begin
            res_hit_s   = spl_valid_r[s] & S_READY[s] & M_REQ[spl_owner_r[s]];
            res_slave_s = res_hit_s ? SLV_W'(s) : res_slave_s;
            res_owner_s = res_hit_s ? spl_owner_r[s] : res_owner_s;
            res_found_s = res_found_s | res_hit_s;
        end
    end

    // Lowest-numbered slave requesting a split this cycle.
    always_comb begin
        spl_slave_s = {SLV_W{1'b0}};
        for (int s = N_SLAVES - 1; s >= 0; s--) begin
            spl_slave_s = S_SPLIT[s] ? SLV_W'(s) : spl_slave_s;
        end
    end

    assign spl_any_s = |S_SPLIT;
`else
    logic unused_split_s;

    assign parked_s       = {N_MASTERS{1'b0}};
    assign unused_split_s = ^{S_SPLIT, S_READY};
`endif

    assign elig_s = M_REQ & ~parked_s;

    // First eligible master after rr_ptr_r, wrapping modulo N_MASTERS.
    always_comb begin
        rr_idx_s   = rr_ptr_r;
        rr_cand_s  = rr_ptr_r;
        rr_found_s = |elig_s;
        for (int k = N_MASTERS; k >= 1; k--) begin
            rr_cand_s = IDX_W'((int'(rr_ptr_r) + k) % N_MASTERS);
            rr_idx_s  = elig_s[rr_cand_s] ? rr_cand_s : rr_idx_s;
        end
    end

    // Next-state, grant, pointer, timeout and split-table logic.
    always_comb begin
        state_nxt_s   = state_r;
        grant_nxt_s   = grant_r;
        gnt_idx_nxt_s = gnt_idx_r;
        rr_ptr_nxt_s  = rr_ptr_r;
        cnt_nxt_s     = cnt_r;
`ifdef ARB_SPLIT_EN
        spl_valid_nxt_s = spl_valid_r;
        spl_owner_nxt_s = spl_owner_r;
        b_split_nxt_s   = 1'b0;
        resume_nxt_s    = resume_r;
`endif
        case (state_r)
            IDLE: begin
                cnt_nxt_s = {CNT_W{1'b0}};
`ifdef ARB_SPLIT_EN
                if (res_found_s) begin
                    // Resume beats round-robin; the entry frees as the grant appears.
                    grant_nxt_s                  = idx_onehot(res_owner_s);
                    gnt_idx_nxt_s                = res_owner_s;
                    spl_valid_nxt_s[res_slave_s] = 1'b0;
                    resume_nxt_s                 = 1'b1;
                    state_nxt_s                  = GRANT;
                end else
`endif
                if (rr_found_s) begin
                    grant_nxt_s   = idx_onehot(rr_idx_s);
                    gnt_idx_nxt_s = rr_idx_s;
                    state_nxt_s   = GRANT;
                end else begin
                    grant_nxt_s = {N_MASTERS{1'b0}};
                    state_nxt_s = IDLE;
                end
            end
            GRANT: begin
                if (B_UTIL) begin
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = UTIL;
                end else if (!M_REQ[gnt_idx_r]) begin
                    // Requester withdrew before using the bus; pointer untouched.
                    grant_nxt_s = {N_MASTERS{1'b0}};
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = IDLE;
                end else if (cnt_r == CNT_W'(GRANT_TIMEOUT - 1)) begin
                    // Revoke an unused grant; a revoked resume stays lost.
                    grant_nxt_s  = {N_MASTERS{1'b0}};
                    rr_ptr_nxt_s = gnt_idx_r;
                    cnt_nxt_s    = {CNT_W{1'b0}};
                    state_nxt_s  = IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + 1'b1;
                end
            end
            UTIL: begin
                if (B_UTIL) begin
`ifdef ARB_SPLIT_EN
                    if (spl_any_s && !spl_valid_r[spl_slave_s]) begin
                        spl_valid_nxt_s[spl_slave_s] = 1'b1;
                        spl_owner_nxt_s[spl_slave_s] = gnt_idx_r;
                        b_split_nxt_s                = 1'b1;
                        grant_nxt_s                  = {N_MASTERS{1'b0}};
                        rr_ptr_nxt_s                 = gnt_idx_r;
                        state_nxt_s                  = IDLE;
                    end else begin
                        // No split, or the slave already holds a parked master.
                        state_nxt_s = UTIL;
                    end
`else
                    state_nxt_s = UTIL;
`endif
                end else begin
                    grant_nxt_s  = {N_MASTERS{1'b0}};
                    rr_ptr_nxt_s = gnt_idx_r;
                    state_nxt_s  = IDLE;
                end
            end
            default: begin
                grant_nxt_s = {N_MASTERS{1'b0}};
                cnt_nxt_s   = {CNT_W{1'b0}};
                state_nxt_s = IDLE;
            end
        endcase
`ifdef ARB_SPLIT_EN
        // Resume flag lives exactly as long as the grant it marks.
        resume_nxt_s = resume_nxt_s & (|grant_nxt_s);
`endif
    end

    // Arbitration state, grant, pointer and timeout registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r   <= IDLE;
            grant_r   <= {N_MASTERS{1'b0}};
            gnt_idx_r <= {IDX_W{1'b0}};
            rr_ptr_r  <= IDX_W'(N_MASTERS - 1);
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            grant_r   <= grant_nxt_s;
            gnt_idx_r <= gnt_idx_nxt_s;
            rr_ptr_r  <= rr_ptr_nxt_s;
            cnt_r     <= cnt_nxt_s;
        end
    end

`ifdef ARB_SPLIT_EN
    // Split table and split status flags.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            spl_valid_r <= {N_SLAVES{1'b0}};
            b_split_r   <= 1'b0;
            resume_r    <= 1'b0;
            for (int s = 0; s < N_SLAVES; s++) begin
                spl_owner_r[s] <= {IDX_W{1'b0}};
            end
        end else begin
            spl_valid_r <= spl_valid_nxt_s;
            spl_owner_r <= spl_owner_nxt_s;
            b_split_r   <= b_split_nxt_s;
            resume_r    <= resume_nxt_s;
        end
    end

    assign B_SPLIT      = b_split_r;
    assign B_SPL_RESUME = resume_r;
    assign SPLIT_PEND   = spl_valid_r;
`else
    assign B_SPLIT      = 1'b0;
    assign B_SPL_RESUME = 1'b0;
    assign SPLIT_PEND   = {N_SLAVES{1'b0}};
`endif

    assign M_GRANT = grant_r;

endmodule

// File: tb/tb_split_rr_arbiter.sv
`timescale 1ns/1ps
// tb_split_rr_arbiter
// Directed test of split_rr_arbiter (4 masters, 3 slaves, timeout 16).
// Split scenarios run when ARB_SPLIT_EN is defined; otherwise the bench
// checks that split inputs are ignored and split outputs stay low.

module tb_split_rr_arbiter;

    logic       CLK;
    logic       RSTN;
    logic [3:0] M_REQ;
    logic [3:0] M_GRANT;
    logic       B_UTIL;
    logic [2:0] S_SPLIT;
    logic [2:0] S_READY;
    logic       B_SPLIT;
    logic       B_SPL_RESUME;
    logic [2:0] SPLIT_PEND;

    int check_cnt = 0;
    int fail_cnt  = 0;

    split_rr_arbiter #(
        .N_MASTERS     (4),
        .N_SLAVES      (3),
        .GRANT_TIMEOUT (16)
    ) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .M_REQ        (M_REQ),
        .M_GRANT      (M_GRANT),
        .B_UTIL       (B_UTIL),
        .S_SPLIT      (S_SPLIT),
        .S_READY      (S_READY),
        .B_SPLIT      (B_SPLIT),
        .B_SPL_RESUME (B_SPL_RESUME),
        .SPLIT_PEND   (SPLIT_PEND)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Grant already visible: hold B_UTIL for 3 cycles, release, check the dead cycle.
    task automatic do_xfer(input string tag, input logic [3:0] exp_gnt);
        check_eq(tag, M_GRANT, exp_gnt);
        B_UTIL = 1'b1;
        tick();
        tick();
        tick();
        check_eq({tag, "_hold"}, M_GRANT, exp_gnt);
        B_UTIL = 1'b0;
        tick();
        check_eq({tag, "_dead"}, M_GRANT, 4'b0000);
        tick();
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        RSTN    = 1'b0;
        M_REQ   = 4'b0000;
        B_UTIL  = 1'b0;
        S_SPLIT = 3'b000;
        S_READY = 3'b000;
        tick();

        // Reset values
        check_eq("rst_grant",  M_GRANT,      4'b0000);
        check_eq("rst_split",  B_SPLIT,      1'b0);
        check_eq("rst_resume", B_SPL_RESUME, 1'b0);
        check_eq("rst_pend",   SPLIT_PEND,   3'b000);

        // Round-robin with all masters requesting
        RSTN  = 1'b1;
        M_REQ = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            do_xfer($sformatf("rr%0d", i), rr_exp[i]);
        end
        check_eq("rr_next",        M_GRANT,      4'b0010);
        check_eq("rr_no_resume",   B_SPL_RESUME, 1'b0);
        M_REQ = 4'b0000;
        tick();
        check_eq("req_drop",       M_GRANT,      4'b0000);

        // Timeout: master 2 never uses the bus
        M_REQ = 4'b0100;
        tick();
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("tmo_hold%0d", i), M_GRANT, 4'b0100);
            tick();
        end
        check_eq("tmo_revoke", M_GRANT, 4'b0000);
        M_REQ = 4'b1100;
        tick();
        check_eq("tmo_next_m3", M_GRANT, 4'b1000);
        M_REQ = 4'b0000;
        tick();
        check_eq("tmo_m3_drop", M_GRANT, 4'b0000);

`ifdef ARB_SPLIT_EN
        // Split of master 1 by slave 1, then resume
        M_REQ = 4'b0010;
        tick();
        check_eq("spl_gnt1", M_GRANT, 4'b0010);
        B_UTIL = 1'b1;
        tick();
        S_SPLIT = 3'b010;
        tick();
        check_eq("spl_gnt_off", M_GRANT,    4'b0000);
        check_eq("spl_pulse",   B_SPLIT,    1'b1);
        check_eq("spl_pend",    SPLIT_PEND, 3'b010);
        S_SPLIT = 3'b000;
        B_UTIL  = 1'b0;
        M_REQ   = 4'b0011;
        tick();
        check_eq("spl_m0",        M_GRANT,    4'b0001);
        check_eq("spl_pulse_end", B_SPLIT,    1'b0);
        check_eq("spl_pend_hold", SPLIT_PEND, 3'b010);
        B_UTIL = 1'b1;
        tick();
        B_UTIL = 1'b0;
        tick();
        tick();
        check_eq("spl_parked", M_GRANT, 4'b0001);
        M_REQ = 4'b0010;
        tick();
        check_eq("spl_m0_drop", M_GRANT, 4'b0000);
        S_READY = 3'b010;
        tick();
        check_eq("res_gnt",    M_GRANT,      4'b0010);
        check_eq("res_flag",   B_SPL_RESUME, 1'b1);
        check_eq("res_pend",   SPLIT_PEND,   3'b000);
        S_READY = 3'b000;
        B_UTIL  = 1'b1;
        tick();
        check_eq("res_flag_util", B_SPL_RESUME, 1'b1);
        B_UTIL = 1'b0;
        tick();
        check_eq("res_rel_gnt",  M_GRANT,      4'b0000);
        check_eq("res_rel_flag", B_SPL_RESUME, 1'b0);
        M_REQ = 4'b0000;

        // Concurrent splits: master 2 by slave 2, master 0 by slave 0
        M_REQ = 4'b0101;
        tick();
        check_eq("conc_m2", M_GRANT, 4'b0100);
        B_UTIL = 1'b1;
        tick();
        S_SPLIT = 3'b100;
        tick();
        check_eq("conc_pend2", SPLIT_PEND, 3'b100);
        S_SPLIT = 3'b000;
        B_UTIL  = 1'b0;
        tick();
        check_eq("conc_m0", M_GRANT, 4'b0001);
        B_UTIL = 1'b1;
        tick();
        S_SPLIT = 3'b001;
        tick();
        check_eq("conc_pend02", SPLIT_PEND, 3'b101);
        check_eq("conc_pulse0", B_SPLIT,    1'b1);
        S_SPLIT = 3'b000;
        B_UTIL  = 1'b0;
        S_READY = 3'b101;
        tick();
        check_eq("conc_res_m0",   M_GRANT,      4'b0001);
        check_eq("conc_res_flag", B_SPL_RESUME, 1'b1);
        check_eq("conc_pend_2",   SPLIT_PEND,   3'b100);
        B_UTIL = 1'b1;
        tick();
        B_UTIL = 1'b0;
        tick();
        check_eq("conc_rel0", M_GRANT, 4'b0000);
        tick();
        check_eq("conc_res_m2",  M_GRANT,      4'b0100);
        check_eq("conc_res2_fl", B_SPL_RESUME, 1'b1);
        check_eq("conc_pend_0",  SPLIT_PEND,   3'b000);
        B_UTIL = 1'b1;
        tick();
        B_UTIL  = 1'b0;
        S_READY = 3'b000;
        M_REQ   = 4'b0000;
        tick();
        check_eq("conc_rel2", M_GRANT, 4'b0000);

        // Occupied slave: slave 1 parked, master 3 split request ignored
        M_REQ = 4'b0010;
        tick();
        check_eq("occ_m1", M_GRANT, 4'b0010);
        B_UTIL = 1'b1;
        tick();
        S_SPLIT = 3'b010;
        tick();
        check_eq("occ_pend", SPLIT_PEND, 3'b010);
        S_SPLIT = 3'b000;
        B_UTIL  = 1'b0;
        M_REQ   = 4'b1000;
        tick();
        check_eq("occ_m3", M_GRANT, 4'b1000);
        B_UTIL = 1'b1;
        tick();
        S_SPLIT = 3'b010;
        tick();
        check_eq("occ_no_split", B_SPLIT,    1'b0);
        check_eq("occ_keep",     M_GRANT,    4'b1000);
        check_eq("occ_pend_keep", SPLIT_PEND, 3'b010);
        tick();
        check_eq("occ_keep2", M_GRANT, 4'b1000);
        S_SPLIT = 3'b000;
        B_UTIL  = 1'b0;
        tick();
        check_eq("occ_rel", M_GRANT, 4'b0000);
        M_REQ = 4'b0000;
`else
        // Split inputs have no effect when the feature is absent
        M_REQ = 4'b0010;
        tick();
        check_eq("ign_m1", M_GRANT, 4'b0010);
        B_UTIL  = 1'b1;
        S_SPLIT = 3'b111;
        S_READY = 3'b111;
        tick();
        tick();
        check_eq("ign_keep",   M_GRANT,      4'b0010);
        check_eq("ign_split",  B_SPLIT,      1'b0);
        check_eq("ign_pend",   SPLIT_PEND,   3'b000);
        check_eq("ign_resume", B_SPL_RESUME, 1'b0);
        S_SPLIT = 3'b000;
        S_READY = 3'b000;
        B_UTIL  = 1'b0;
        tick();
        check_eq("ign_rel", M_GRANT, 4'b0000);
        M_REQ = 4'b0000;
`endif

        // Asynchronous reset during a transfer
        M_REQ = 4'b1000;
        tick();
        check_eq("rmid_m3", M_GRANT, 4'b1000);
        B_UTIL = 1'b1;
        tick();
        #2;
        RSTN = 1'b0;
        #1;
        check_eq("rmid_grant",  M_GRANT,      4'b0000);
        check_eq("rmid_pend",   SPLIT_PEND,   3'b000);
        check_eq("rmid_resume", B_SPL_RESUME, 1'b0);
        M_REQ  = 4'b1111;
        B_UTIL = 1'b0;
        #1;
        RSTN = 1'b1;
        tick();
        check_eq("rmid_first_m0", M_GRANT, 4'b0001);
        M_REQ = 4'b0000;
        tick();
        check_eq("rmid_drop", M_GRANT, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/split_rr_arbiter.md
# split_rr_arbiter

Parametrised round-robin bus arbiter with per-slave split-transaction tracking, for N masters and M slaves on the shared system bus. It grants one master at a time and holds the grant while the bus is in use. It parks masters whose transaction was split by a slave, then gives them priority once that slave signals ready. It is the multi-master, multi-split successor to the two-master arbiter.

## Interface
- N_MASTERS, 4, number of requesting masters (2..8)
- N_SLAVES, 3, number of split-capable slaves (1..8)
- GRANT_TIMEOUT, 16, cycles allowed from grant to B_UTIL before the grant is revoked (≥2)

Ports:
- CLK  in  1  clock, rising edge
- RSTN  in  1  reset, asynchronous, active-low
- M_REQ  in  N_MASTERS  per-master bus request, level
- M_GRANT  out  N_MASTERS  one-hot grant (all-zero when no grant)
- B_UTIL  in  1  granted master is driving the bus
- S_SPLIT  in  N_SLAVES  slave requests split of the current transfer (sampled only in UTIL)
- S_READY  in  N_SLAVES  split slave ready to resume
- B_SPLIT  out  1  one-cycle pulse: current transfer split and grant withdrawn
- B_SPL_RESUME  out  1  high for every cycle the current grant is a split resume
- SPLIT_PEND  out  N_SLAVES  bit s set while slave s holds a parked master

## Operation
- FSM states: IDLE, GRANT, UTIL. Reset state is IDLE.
- Eligible masters: M_REQ[i]=1 and i not parked in any split entry.
- Split table: one entry per slave, holding valid and owner index ($clog2(N_MASTERS) bits).
- IDLE, resume candidate present: a resume candidate is slave s with valid=1 and S_READY[s]=1; lowest s wins. Its owner is granted if M_REQ[owner]=1, regardless of round-robin. The entry is cleared, B_SPL_RESUME is set, go to GRANT.
- IDLE, otherwise: if any master is eligible, grant the first one searching from rr_ptr+1 upward with wrap modulo N_MASTERS. Go to GRANT.
- GRANT: the timeout counter counts from 0.
  - B_UTIL=1 → UTIL.
  - M_REQ of the granted master drops → IDLE, grant cleared.
  - Counter reaches GRANT_TIMEOUT-1 → IDLE, grant cleared, rr_ptr ← granted index.
  - A revoked resume grant does not restore its split entry.
- UTIL, B_UTIL=1 with any S_SPLIT bit set: take the lowest set s.
  - If entry s is invalid: store the owner, set valid, pulse B_SPLIT, clear the grant, rr_ptr ← owner, go to IDLE.
  - If entry s is already valid: S_SPLIT is ignored and the transfer continues.
- UTIL, B_UTIL=0: clear the grant, rr_ptr ← granted index, go to IDLE.
- rr_ptr resets to N_MASTERS-1, so master 0 wins first.
- S_READY on an invalid entry is ignored.
- Multiple entries may be valid at once. A parked master's M_REQ is ignored until its resume.

## Timing
- Reset values: M_GRANT=0, B_SPLIT=0, B_SPL_RESUME=0, SPLIT_PEND=0, table cleared, rr_ptr=N_MASTERS-1, counter=0.
- Reset mid-transfer: everything returns to reset values immediately (asynchronous), and parked masters are lost.
- Latency from request to grant: M_REQ sampled in IDLE at edge k gives M_GRANT valid after edge k. Minimum 1 cycle.
- Grant release: UTIL with B_UTIL=0 at edge k gives M_GRANT=0 after edge k. The earliest next grant is after edge k+1, so there is one dead IDLE cycle.
- B_SPLIT is registered: high for exactly the cycle after the split sample, coincident with M_GRANT=0.
- SPLIT_PEND updates in the same cycle as B_SPLIT. It clears on the cycle the resume grant appears.
- B_SPL_RESUME rises with M_GRANT and falls when the grant is cleared.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- ARB_SPLIT_EN defined: split table, resume priority, B_SPLIT, B_SPL_RESUME and SPLIT_PEND operate as above.
- ARB_SPLIT_EN undefined: no split table is built. S_SPLIT and S_READY are ignored. B_SPLIT, B_SPL_RESUME and SPLIT_PEND are tied to 0. The arbiter is pure round-robin with timeout.

## Test plan
- Round-robin: N_MASTERS=4, M_REQ=4'b1111, each transfer holds B_UTIL for 3 cycles → grants 0,1,2,3,0 in order, one dead cycle between grants.
- Timeout: master 2 requests and never asserts B_UTIL → M_GRANT=4'b0100 for exactly 16 cycles, then 0. The next request from master 3 is granted before master 2.
- Split and resume: master 1 in UTIL, S_SPLIT=3'b010 → B_SPLIT pulse, SPLIT_PEND=3'b010, master 1 not granted while master 0 is served. Then S_READY[1]=1 → master 1 granted with B_SPL_RESUME=1, SPLIT_PEND=0.
- Concurrent splits: master 0 split by slave 0, master 2 split by slave 2, both S_READY asserted together → master 0 resumed first, then master 2.
- Occupied slave: slave 1 already pending, new S_SPLIT[1] during master 3's transfer → no B_SPLIT, master 3 keeps its grant until B_UTIL falls.
- Reset mid-UTIL: RSTN low during a granted transfer with one split pending → M_GRANT=0 and SPLIT_PEND=0 immediately. After release, master 0 wins the first arbitration.
